// File: rtl/draw_sprite_multi_pkg.sv
// Shared definitions for the multi-sprite drawing stage: timing bus widths,
// the timing bus record carried down the delay line, and the sprite slicer.
package draw_sprite_multi_pkg;

  localparam int CNT_W   = 11;   // hcount / vcount width
  localparam int RGB_W   = 12;   // 4:4:4 colour
  localparam int POS_W   = 12;   // sprite position width
  localparam int MAX_SPR = 8;    // widest sprite bus the slicer accepts

  localparam logic [RGB_W-1:0] KEY_RGB_DEFAULT = 12'h000;

  typedef logic [POS_W*MAX_SPR-1:0] spr_bus_t;

  // Everything that travels alongside the pixel with fixed latency.
  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;
  } timing_t;

  // Pick sprite idx's 12-bit field out of a packed per-sprite bus.
  function automatic logic [POS_W-1:0] slice12(input spr_bus_t bus, input int idx);
    return bus[POS_W*idx +: POS_W];
  endfunction

endpackage

// File: rtl/draw_sprite_multi_sprite_hit_addr.sv
// One sprite: frame-synchronous shadow copy of position/enable, plus the
// first pipeline stage (hit test and ROM address).
module sprite_hit_addr
  import draw_sprite_multi_pkg::*;
#(
  parameter int SPR_W  = 48,
  parameter int SPR_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              load,
  input  logic [POS_W-1:0]  xpos,
  input  logic [POS_W-1:0]  ypos,
  input  logic              en,
  input  logic [CNT_W-1:0]  hcount,
  input  logic [CNT_W-1:0]  vcount,
  input  logic              blank_n,
  output logic              hit,
  output logic [ADDR_W-1:0] pixel_addr
);

  logic [POS_W-1:0]  x_reg;
  logic [POS_W-1:0]  y_reg;
  logic              en_reg;

  // 13-bit operands so that x+SPR_W never wraps back onto the left edge.
  logic [12:0]       h13, v13, x13, y13, dx, dy;
  logic              hit_next;
  logic [ADDR_W-1:0] addr_next;

  assign h13 = {2'b00, hcount};
  assign v13 = {2'b00, vcount};
  assign x13 = {1'b0, x_reg};
  assign y13 = {1'b0, y_reg};
  assign dx  = h13 - x13;
  assign dy  = v13 - y13;

  assign hit_next = en_reg & blank_n
                  & (h13 >= x13) & (h13 < x13 + 13'(SPR_W))
                  & (v13 >= y13) & (v13 < y13 + 13'(SPR_H));

  // Modular arithmetic in ADDR_W bits gives the truncated linear address.
  assign addr_next = hit_next ? (ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx)) : '0;

  // Shadow registers only change on the vblank rising edge (tear-free update).
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      x_reg  <= '0;
      y_reg  <= '0;
      en_reg <= 1'b0;
    end else if (load) begin
      x_reg  <= xpos;
      y_reg  <= ypos;
      en_reg <= en;
    end
  end

  // Stage 1: register hit flag and ROM address.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hit        <= 1'b0;
      pixel_addr <= '0;
    end else begin
      hit        <= hit_next;
      pixel_addr <= addr_next;
    end
  end

endmodule

// File: rtl/draw_sprite_multi.sv
// Overlays N_SPR colour-keyed bitmap sprites on the pixel stream with a
// fixed 3-cycle latency on every output; lower index has higher priority.
module draw_sprite_multi
  import draw_sprite_multi_pkg::*;
#(
  parameter int          N_SPR   = 4,
  parameter int          SPR_W   = 48,
  parameter int          SPR_H   = 64,
  parameter int          ADDR_W  = 12,
  parameter logic [11:0] KEY_RGB = KEY_RGB_DEFAULT
) (
  input  logic                      pclk,
  input  logic                      rst,
  input  logic [10:0]               hcount_in,
  input  logic [10:0]               vcount_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      hblnk_in,
  input  logic                      vblnk_in,
  input  logic [11:0]               rgb_in,
  input  logic [12*N_SPR-1:0]       xpos_in,
  input  logic [12*N_SPR-1:0]       ypos_in,
  input  logic [N_SPR-1:0]          spr_en_in,
  output logic [ADDR_W*N_SPR-1:0]   pixel_addr,
  input  logic [12*N_SPR-1:0]       rgb_pixel,
  output logic [10:0]               hcount_out,
  output logic [10:0]               vcount_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      hblnk_out,
  output logic                      vblnk_out,
  output logic [11:0]               rgb_out,
  output logic                      hit_any
);

  logic             vblnk_prev;
  logic             load;
  logic             blank_n;
  timing_t          tim_in, tim1_reg, tim2_reg;
  logic [N_SPR-1:0] hit1;
  logic [N_SPR-1:0] hit2_reg;
  logic [11:0]      rgb_next;
  logic             hit_next;

  assign load    = vblnk_in & ~vblnk_prev;
  assign blank_n = ~(hblnk_in | vblnk_in);
  assign tim_in  = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};

  genvar gi;
  generate
    for (gi = 0; gi < N_SPR; gi++) begin : g_spr
      sprite_hit_addr #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .ADDR_W (ADDR_W)
      ) u_hit (
        .pclk       (pclk),
        .rst        (rst),
        .load       (load),
        .xpos       (slice12(spr_bus_t'(xpos_in), gi)),
        .ypos       (slice12(spr_bus_t'(ypos_in), gi)),
        .en         (spr_en_in[gi]),
        .hcount     (hcount_in),
        .vcount     (vcount_in),
        .blank_n    (blank_n),
        .hit        (hit1[gi]),
        .pixel_addr (pixel_addr[ADDR_W*gi +: ADDR_W])
      );
    end
  endgenerate

  // Stage 3 compositing: scan from lowest priority up so sprite 0 wins last.
  always_comb begin
    rgb_next = tim2_reg.rgb;
    hit_next = 1'b0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (hit2_reg[i] && (rgb_pixel[12*i +: 12] != KEY_RGB)) begin
        rgb_next = rgb_pixel[12*i +: 12];
        hit_next = 1'b1;
      end
    end
    if (tim2_reg.hblnk || tim2_reg.vblnk) begin
      rgb_next = 12'h000;
      hit_next = 1'b0;
    end
  end

  // Timing delay line, vblank edge tracker and registered outputs.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vblnk_prev <= 1'b0;
      tim1_reg   <= '0;
      tim2_reg   <= '0;
      hit2_reg   <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
      hit_any    <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      tim1_reg   <= tim_in;
      tim2_reg   <= tim1_reg;
      hit2_reg   <= hit1;
      hcount_out <= tim2_reg.hcount;
      vcount_out <= tim2_reg.vcount;
      hsync_out  <= tim2_reg.hsync;
      vsync_out  <= tim2_reg.vsync;
      hblnk_out  <= tim2_reg.hblnk;
      vblnk_out  <= tim2_reg.vblnk;
      rgb_out    <= rgb_next;
      hit_any    <= hit_next;
    end
  end

endmodule

// File: tb/tb_draw_sprite_multi.sv
// Scoreboard bench for draw_sprite_multi: directed pixel vectors with
// hand-computed expected colours, checked by a decoupled monitor.
module tb_draw_sprite_multi;

  localparam int N  = 4;
  localparam int AW = 12;

  logic          pclk = 1'b0;
  logic          rst;
  logic [10:0]   hcount_in, vcount_in;
  logic          hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0]   rgb_in;
  logic [12*N-1:0] xpos_in, ypos_in;
  logic [N-1:0]  spr_en_in;
  logic [AW*N-1:0] pixel_addr;
  logic [12*N-1:0] rgb_pixel = '0;
  logic [10:0]   hcount_out, vcount_out;
  logic          hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0]   rgb_out;
  logic          hit_any;

  draw_sprite_multi #(.N_SPR(N), .SPR_W(48), .SPR_H(64), .ADDR_W(AW), .KEY_RGB(12'h000)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos_in(xpos_in), .ypos_in(ypos_in), .spr_en_in(spr_en_in),
    .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .hit_any(hit_any)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Sprite ROM model, one cycle read latency.
  bit rom_mode3 = 1'b0;
  function automatic logic [11:0] rom(input int i, input logic [11:0] a);
    if (i == 0) begin
      if (rom_mode3) return (a == 12'd0) ? 12'h000 : 12'hF00;
      return a;
    end
    if (i == 1) return 12'h0F0;
    return 12'h00F;
  endfunction

  always @(posedge pclk) begin
    for (int i = 0; i < N; i++)
      rgb_pixel[12*i +: 12] <= rom(i, pixel_addr[AW*i +: AW]);
  end

  typedef struct { int due; logic [11:0] rgb; logic hit; logic [25:0] tim; } out_exp_t;
  typedef struct { int due; int addr; } addr_exp_t;
  out_exp_t  out_q[$];
  addr_exp_t addr_q[$];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare outputs against the scoreboard whenever an entry falls due.
  always @(negedge pclk) begin
    out_exp_t  e;
    addr_exp_t a;
    if (out_q.size() > 0 && out_q[0].due == cyc) begin
      e = out_q.pop_front();
      $display("txn cyc=%0d h=%0d v=%0d rgb_out=%h (exp %h) hit_any=%b (exp %b)",
               cyc, hcount_out, vcount_out, rgb_out, e.rgb, hit_any, e.hit);
      chk("rgb_out", int'(rgb_out), int'(e.rgb));
      chk("hit_any", int'(hit_any), int'(e.hit));
      chk("timing", int'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), int'(e.tim));
    end
    if (addr_q.size() > 0 && addr_q[0].due == cyc) begin
      a = addr_q.pop_front();
      $display("txn cyc=%0d pixel_addr0=%0d (exp %0d)", cyc, pixel_addr[AW-1:0], a.addr);
      chk("pixel_addr0", int'(pixel_addr[AW-1:0]), a.addr);
    end
  end

  // Put one pixel on the bus (no clock wait) and queue its expected response.
  task automatic apply(input int h, input int v, input bit hb, input bit vb, input logic [11:0] bg,
                       input logic [11:0] exp_rgb, input bit exp_hit, input int exp_addr = -1);
    out_exp_t  e;
    addr_exp_t a;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = vb;
    hsync_in  = (h >= 1048 && h < 1184);
    vsync_in  = (v >= 771 && v < 777);
    rgb_in    = bg;
    e.due = cyc + 3;
    e.rgb = exp_rgb;
    e.hit = exp_hit;
    e.tim = {11'(h), 11'(v), hsync_in, vsync_in, hb, vb};
    out_q.push_back(e);
    if (exp_addr >= 0) begin
      a.due  = cyc + 1;
      a.addr = exp_addr;
      addr_q.push_back(a);
    end
  endtask

  task automatic vec(input int h, input int v, input bit hb, input bit vb, input logic [11:0] bg,
                     input logic [11:0] exp_rgb, input bit exp_hit, input int exp_addr = -1);
    @(posedge pclk); #1;
    apply(h, v, hb, vb, bg, exp_rgb, exp_hit, exp_addr);
  endtask

  // Frame boundary: last active line then vblank rising edge (shadow load).
  task automatic vblank_pulse();
    vec(0, 767, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0);
    vec(0, 768, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (out_q.size() > 0 || addr_q.size() > 0); i++) @(posedge pclk);
    if (out_q.size() > 0 || addr_q.size() > 0)
      chk("drain_timeout", out_q.size() + addr_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
    rgb_in = '0; xpos_in = '0; ypos_in = '0; spr_en_in = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    chk("reset_rgb", int'(rgb_out), 0);
    chk("reset_hit", int'(hit_any), 0);
    chk("reset_addr_nonzero", int'(pixel_addr != '0), 0);
    chk("reset_timing", int'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 0);
    rst = 1'b0;

    // 1: all sprites disabled, pure 3-cycle pass-through
    vec(0,    0,   0, 0, 12'h123, 12'h123, 0);
    vec(500,  300, 0, 0, 12'h456, 12'h456, 0);
    vec(1023, 767, 0, 0, 12'h789, 12'h789, 0);
    vec(1100, 10,  1, 0, 12'hFFF, 12'h000, 0);
    vec(5,    780, 0, 1, 12'hEEE, 12'h000, 0);
    drain();

    // 2: sprite 0 at (100,200), ROM returns address as colour
    xpos_in[11:0] = 12'd100; ypos_in[11:0] = 12'd200; spr_en_in = 4'b0001;
    vblank_pulse();
    vec(100, 200, 0, 0, 12'h111, 12'h111, 0, 0);     // addr 0 is key colour
    vec(101, 200, 0, 0, 12'h111, 12'h001, 1, 1);
    vec(147, 263, 0, 0, 12'h222, 12'hBFF, 1, 3071);
    vec(148, 263, 0, 0, 12'h333, 12'h333, 0, 0);
    vec(99,  200, 0, 0, 12'h444, 12'h444, 0, 0);
    vec(100, 264, 0, 0, 12'h445, 12'h445, 0, 0);
    vec(120, 230, 0, 0, 12'h000, 12'h5B4, 1, 1460);
    drain();

    // 3: sprites 0 and 1 overlapping at (300,300)
    rom_mode3 = 1'b1;
    xpos_in[23:0] = {12'd300, 12'd300}; ypos_in[23:0] = {12'd300, 12'd300}; spr_en_in = 4'b0011;
    vblank_pulse();
    vec(300, 300, 0, 0, 12'h555, 12'h0F0, 1);
    vec(301, 300, 0, 0, 12'h555, 12'hF00, 1);
    vec(347, 363, 0, 0, 12'h555, 12'hF00, 1);
    vec(348, 300, 0, 0, 12'h666, 12'h666, 0);
    drain();

    // 4: mid-frame position change only takes effect after the next vblank
    rom_mode3 = 1'b0;
    xpos_in[23:0] = {12'd0, 12'd100}; ypos_in[23:0] = {12'd0, 12'd200}; spr_en_in = 4'b0001;
    vblank_pulse();
    vec(101, 200, 0, 0, 12'h001, 12'h001, 1);
    xpos_in[11:0] = 12'd400;
    vec(101, 260, 0, 0, 12'h000, 12'hB41, 1, 2881);
    vec(401, 260, 0, 0, 12'h777, 12'h777, 0, 0);
    vblank_pulse();
    vec(101, 260, 0, 0, 12'h888, 12'h888, 0);
    vec(401, 260, 0, 0, 12'h000, 12'hB41, 1);
    drain();

    // 5: new position applied on the exact load cycle; sprite clipped at right edge
    vec(0, 767, 0, 0, 12'h000, 12'h000, 0);
    @(posedge pclk); #1;
    xpos_in[11:0] = 12'd1000; ypos_in[11:0] = 12'd100;
    apply(0, 768, 0, 1, 12'h000, 12'h000, 0);
    vec(1000, 101, 0, 0, 12'hAAA, 12'h030, 1, 48);
    vec(1023, 101, 0, 0, 12'hAAA, 12'h047, 1, 71);
    vec(1024, 101, 1, 0, 12'hBBB, 12'h000, 0);
    vec(0,    101, 0, 0, 12'hCCC, 12'hCCC, 0, 0);
    vec(23,   101, 0, 0, 12'hDDD, 12'hDDD, 0, 0);
    vec(1030, 101, 1, 0, 12'hEEE, 12'h000, 0);
    drain();

    // 6: reset mid-line clears everything at once; enables come back only at vblank
    @(posedge pclk); #1;
    hcount_in = 11'd1001; vcount_in = 11'd101; hblnk_in = 0; vblnk_in = 0;
    hsync_in = 0; vsync_in = 0; rgb_in = 12'h123;
    repeat (3) @(posedge pclk);
    #1;
    chk("pre_rst_rgb", int'(rgb_out), 12'h031);
    chk("pre_rst_hit", int'(hit_any), 1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_rgb", int'(rgb_out), 0);
    chk("async_rst_hit", int'(hit_any), 0);
    chk("async_rst_addr_nonzero", int'(pixel_addr != '0), 0);
    chk("async_rst_timing", int'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 0);
    repeat (2) @(posedge pclk);
    #1 rst = 1'b0;
    vec(1001, 101, 0, 0, 12'h123, 12'h123, 0, 0);
    vec(1001, 102, 0, 0, 12'h124, 12'h124, 0, 0);
    vblank_pulse();
    vec(1001, 101, 0, 0, 12'h123, 12'h031, 1, 49);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/draw_sprite_multi.md
Name: draw_sprite_multi

Overview:
- Parametrised successor to the single-rectangle image drawing stage in the VGA pipeline.
- Overlays up to N_SPR independently positioned bitmap sprites on the incoming pixel stream.
- Per-sprite colour-key transparency, fixed priority, and frame-synchronous (tear-free) position update.
- Sits between draw_background and the text overlay, forwarding the full timing bus with matched latency.

Parameters:
N_SPR, 4, number of sprites (1..8)
SPR_W, 48, sprite width in pixels
SPR_H, 64, sprite height in pixels
ADDR_W, 12, per-sprite ROM address width; SPR_W*SPR_H <= 2**ADDR_W
KEY_RGB, 12'h000, transparent colour key

Ports:
pclk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
hcount_in  in  11  horizontal count
vcount_in  in  11  vertical count
hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing bus
rgb_in  in  12  background pixel
xpos_in  in  12*N_SPR  sprite i left edge at bits [12i+11:12i]
ypos_in  in  12*N_SPR  sprite i top edge
spr_en_in  in  N_SPR  sprite enable
pixel_addr  out  ADDR_W*N_SPR  ROM address per sprite
rgb_pixel  in  12*N_SPR  ROM data per sprite, valid 1 pclk after pixel_addr
hcount_out, vcount_out  out  11 each  delayed timing
hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing
rgb_out  out  12  composited pixel
hit_any  out  1  an opaque sprite pixel was drawn this cycle (aligned with rgb_out)

Behaviour:
- Clock and reset: one clock, pclk. rst is asynchronous and active-high.
- Reset values:
  - all outputs 0, including pixel_addr;
  - shadow position/enable registers 0 (all sprites disabled);
  - pipeline registers 0.
- Shadow load:
  - vblnk_prev register tracks vblnk_in.
  - On the cycle where vblnk_in=1 and vblnk_prev=0, the active xpos/ypos/enable registers take xpos_in/ypos_in/spr_en_in.
  - At all other times the active registers hold, so there are no mid-frame position changes.
- Pipeline, 3 stages, fixed latency 3 pclk on every output:
  - S1 (edge k+1):
    - per sprite, hit_i = en_i & blank_n & (h >= x_i) & (h < x_i+SPR_W) & (v >= y_i) & (v < y_i+SPR_H);
    - comparisons in 13 bits so x_i+SPR_W cannot wrap;
    - pixel_addr_i <= (v-y_i)*SPR_W + (h-x_i), truncated to ADDR_W;
    - when hit_i=0, pixel_addr_i <= 0;
    - timing, rgb_in and the hit vector are registered.
  - S2 (edge k+2): external ROM presents rgb_pixel; timing, rgb and hit are delayed one more stage.
  - S3 (edge k+3), compositing:
    - lowest-index sprite i with hit_i=1 and rgb_pixel_i != KEY_RGB wins; rgb_out <= rgb_pixel_i, hit_any <= 1;
    - otherwise rgb_out <= delayed rgb_in, hit_any <= 0;
    - if delayed hblnk|vblnk, rgb_out <= 0 and hit_any <= 0.
- Boundary conditions:
  - Sprite partially off-screen (x_i > 1023 or x_i+SPR_W > 1024): only on-screen pixels are drawn; no wrap to the left edge.
  - Overlapping sprites: the index priority rule decides.
  - Transparent pixel of the higher-priority sprite: the next-lower-priority opaque sprite shows through.
  - Input change exactly on the shadow-load cycle: the new value is captured.
  - rst asserted mid-frame: all state clears immediately; drawing resumes only after the next vblnk rising edge loads enables.

Decomposition:
- Shared package holds:
  - the timing-bus width constants (11-bit counts, 12-bit RGB);
  - the KEY_RGB default;
  - the function that slices sprite i from a packed bus.
- One sub-module, sprite_hit_addr, is instantiated N_SPR times via generate.
  - It holds one sprite's shadow registers and computes hit and address (stage S1).
  - Top level handles the timing delay line and the S3 priority mux.

Test Plan:
1. Reset, then 1024x768 timing with all spr_en_in=0 -> rgb_out equals rgb_in delayed exactly 3 pclk; hit_any stays 0; timing outputs match inputs delayed 3.
2. Sprite0 at (100,200), enabled, ROM model returns address as colour:
   - at h=100, v=200, pixel_addr0 is 0 one cycle later;
   - at h=147, v=263, pixel_addr0 is 3071;
   - rgb_out shows ROM data 3 cycles after input;
   - h=148 -> background.
3. Sprites 0 and 1 both at (300,300), sprite0 ROM returns 12'h000 at addr 0 and 12'hF00 elsewhere, sprite1 returns 12'h0F0 -> at (300,300) rgb_out is 12'h0F0; at (301,300) it is 12'hF00.
4. Change xpos_in0 from 100 to 400 mid-frame (v=300) -> drawing stays at 100 until the frame ends; it moves to 400 only after the next vblnk_in rising edge.
5. Sprite at x=1000 -> pixels drawn at h=1000..1023 only; nothing at h=0..23 of the same lines; rgb_out=0 during blanking.
6. Assert rst for 2 cycles during an active sprite line -> all outputs 0 asynchronously; no sprite drawn until after the next vblnk rising edge.
